codificador_de_instrucciones: RTL and testbench
===============================================

CODIFICADOR_DE_INSTRUCCIONES -- requirements
Module: codificador_de_instrucciones

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have parameter ADDR_W, default 8, program-memory address width.
REQ-003 The block SHALL have port start, input, 1 bit: pulse that begins a load session at base_addr.
REQ-004 The block SHALL have port base_addr, input, ADDR_W bits: first program-memory address of the session.
REQ-005 The block SHALL have port in_valid, input, 1 bit: instruction fields present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: encoder accepts fields this cycle.
REQ-007 The block SHALL have port in_op, input, 3 bits: opcode, where 000 LOAD imm, 001 LOAD [RY], 010 STORE imm, 011 STORE [RY], 100 MOVE, 101 MATH, 110 JUMP, 111 NOP.
REQ-008 The block SHALL have port in_rx, input, 3 bits: RX register index.
REQ-009 The block SHALL have port in_arg, input, 3 bits: #NUM, RY, ALU op or jump condition, depending on in_op.
REQ-010 The block SHALL have port in_last, input, 1 bit: final instruction of the session.
REQ-011 The block SHALL have port mem_we, output, 1 bit: program-memory write strobe.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: write address.
REQ-013 The block SHALL have port mem_wdata, output, 9 bits: encoded instruction word.
REQ-014 The block SHALL have port busy, output, 1 bit: session in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when the session ends normally.
REQ-016 The block SHALL have port err, output, 1 bit: sticky address-overflow flag, cleared by start.
REQ-017 The block SHALL have port count, output, ADDR_W+1 bits: number of words written in the current session.

Function
REQ-018 The encoding SHALL be mem_wdata = {arg[8:6], rx[5:3], op[2:0]}.
REQ-019 For op 111 (NOP), the encoder SHALL force bits [8:3] to 0.
REQ-020 The FSM SHALL have states IDLE, ACCEPT, WRITE and FINISH.
REQ-021 IDLE: start=1 SHALL load addr=base_addr, clear count and err, and move to ACCEPT; all other inputs SHALL be ignored.
REQ-022 ACCEPT: in_ready SHALL be 1; when in_valid & in_ready, the block SHALL register the encoded word and in_last, then move to WRITE.
REQ-023 WRITE: mem_we SHALL be 1 for exactly one cycle, with mem_addr=addr and mem_wdata=registered word; count SHALL increment by 1.
REQ-024 Latency SHALL be fixed at 1 cycle, from the accept edge to the write cycle; maximum throughput SHALL be one instruction per 2 cycles.
REQ-025 From WRITE, if the registered last=1, the FSM SHALL go to FINISH.
REQ-026 From WRITE, if last=0 and addr=all-ones, the block SHALL set err and go to IDLE with no wrap-around write.
REQ-027 From WRITE, in all other cases, the block SHALL increment addr and return to ACCEPT.
REQ-028 FINISH: done SHALL be 1 for one cycle, then the FSM SHALL go to IDLE.
REQ-029 busy SHALL be 1 in ACCEPT, WRITE and FINISH.
REQ-030 in_ready SHALL be 0 outside ACCEPT.
REQ-031 mem_we SHALL be 0 outside WRITE.
REQ-032 start asserted while busy SHALL be ignored.
REQ-033 in_valid asserted while not ACCEPT SHALL be ignored; the source SHALL hold its fields until accepted.
REQ-034 A session with base_addr=all-ones and a single last instruction SHALL write once and complete with done=1, err=0.

Reset
REQ-035 rst_n=0 SHALL immediately force: state IDLE; in_ready, mem_we, busy, done and err to 0; mem_addr, mem_wdata and count to 0.
REQ-036 Reset asserted mid-session SHALL abort the session, with no further writes and no done pulse.

Structure
REQ-037 A shared package SHALL hold the opcode constants (OP_LOAD_IMM ... OP_NOP), the FSM state encoding and the 9-bit word field positions; the instruction decoder SHALL use the same package.
REQ-038 The block SHALL contain one sub-module, instr_pack (combinational field packer plus NOP canonicalisation), instantiated once.

Verification
REQ-039 Scenario 1: start, base=0x10, then LOAD R3 #5 (last=1) -> write addr 0x10, data 9'b101_011_000, done pulse, count=1.
REQ-040 Scenario 2: three instructions MATH R1 op2, MOVE R2 R7, JUMP R0 cond3 (last on third), in_valid held high -> writes at base, base+1, base+2 with data 9'b010_001_101, 9'b111_010_100, 9'b011_000_110; in_ready low during each write cycle.
REQ-041 Scenario 3: NOP with rx=5, arg=6 -> mem_wdata=9'b000_000_111.
REQ-042 Scenario 4: base=0xFE, three instructions with last on third -> writes at 0xFE and 0xFF, err=1, no write to 0x00, no done pulse, count=2.
REQ-043 Scenario 5: start pulsed during ACCEPT of a live session -> addr and count unchanged, session continues.
REQ-044 Scenario 6: rst_n low in the WRITE cycle -> mem_we drops without waiting for a clock edge; after release busy=0, and the next start begins cleanly with count=0.

Source files
------------

// File: rtl/codificador_de_instrucciones_pkg.sv
// Shared constants for the instruction encoder: opcodes, FSM encoding and
// the bit positions of the fields inside the 9-bit program word.
package codificador_de_instrucciones_pkg;

    // Opcodes (3 bits)
    localparam logic [2:0] OP_LOAD_IMM  = 3'b000;
    localparam logic [2:0] OP_LOAD_REG  = 3'b001;
    localparam logic [2:0] OP_STORE_IMM = 3'b010;
    localparam logic [2:0] OP_STORE_REG = 3'b011;
    localparam logic [2:0] OP_MOVE      = 3'b100;
    localparam logic [2:0] OP_MATH      = 3'b101;
    localparam logic [2:0] OP_JUMP      = 3'b110;
    localparam logic [2:0] OP_NOP       = 3'b111;

    // Encoder FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Program word layout: {arg, rx, op}
    localparam int WORD_W  = 9;
    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 2;
    localparam int RX_LSB  = 3;
    localparam int RX_MSB  = 5;
    localparam int ARG_LSB = 6;
    localparam int ARG_MSB = 8;

endpackage

// File: rtl/codificador_de_instrucciones_instr_pack.sv
// Combinational field packer; NOP words are canonicalised so that the
// rx/arg fields are always zero regardless of what the source presented.
module instr_pack
    import codificador_de_instrucciones_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [2:0]        rx,
    input  logic [2:0]        arg,
    output logic [WORD_W-1:0] word
);

    // Pack fields into their word slots, blanking operands for NOP
    always_comb begin
        word                 = '0;
        word[OP_MSB:OP_LSB]  = op;
        if (op != OP_NOP) begin
            word[RX_MSB:RX_LSB]   = rx;
            word[ARG_MSB:ARG_LSB] = arg;
        end
    end

endmodule

// File: rtl/codificador_de_instrucciones.sv
// Instruction encoder: accepts instruction fields over a valid/ready
// handshake, packs them into 9-bit words and writes them to consecutive
// program-memory addresses starting at base_addr. A session ends on the
// instruction flagged last, or with err if the address space runs out.
module codificador_de_instrucciones
    import codificador_de_instrucciones_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_rx,
    input  logic [2:0]        in_arg,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic              last_q,  last_d;
    logic              err_q,   err_d;
    logic [WORD_W-1:0] packed_word;

    instr_pack u_pack (
        .op   (in_op),
        .rx   (in_rx),
        .arg  (in_arg),
        .word (packed_word)
    );

    // Next-state and datapath updates for the session FSM
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    word_d  = packed_word;
                    last_d  = in_last;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_q + (ADDR_W+1)'(1);
                if (last_q) begin
                    state_d = ST_FINISH;
                end else if (addr_q == '1) begin
                    // Out of address space: abort rather than wrap to 0
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_ACCEPT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State registers; async reset clears everything, aborting any session
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from flops so reset takes effect at once
    assign in_ready  = (state_q == ST_ACCEPT);
    assign mem_we    = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign count     = count_q;

endmodule

// File: tb/tb_codificador_de_instrucciones.sv
// Scoreboard bench for the instruction encoder: the driver pushes expected
// memory writes into a queue, a negedge monitor pops and compares them.
module tb_codificador_de_instrucciones;

    localparam int ADDR_W = 8;
    localparam int AMAX   = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = '0, in_rx = '0, in_arg = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [8:0]        mem_wdata;
    logic              busy, done, err;
    logic [ADDR_W:0]   count;

    codificador_de_instrucciones #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rx(in_rx),
        .in_arg(in_arg), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_seen = 0;
    int  s_op[16], s_rx[16], s_arg[16];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference word: op in units, rx in eights, arg in sixty-fours; NOP has no operands
    function automatic int ref_word(input int op, input int rx, input int arg);
        if (op == 7) return 7;
        return op + 8 * rx + 64 * arg;
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_seen++;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(mem_addr), e.addr);
                    chk("wr_data", int'(mem_wdata), e.data);
                    chk("ready_in_write", int'(in_ready), 0);
                end
            end
        end
    end

    // Pulse start at the next negedge and confirm the session opened cleanly
    task automatic open_session(input int base);
        done_seen = 0;
        base_addr = ADDR_W'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_count", int'(count), 0);
        chk("start_err", int'(err), 0);
        chk("start_addr", int'(mem_addr), base);
    endtask

    // Present one instruction and hold it until accepted; returns at the write negedge
    task automatic send(input int op, input int rx, input int arg, input bit last,
                        input bit poke, input int base, output bit ok);
        int t;
        in_op = 3'(op); in_rx = 3'(rx); in_arg = 3'(arg); in_last = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        ok = in_ready;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", t);
            return;
        end
        if (poke) begin
            start = 1'b1;
            base_addr = ADDR_W'(base ^ 8'h5A);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full session of n instructions from s_* arrays; model decides writes and outcome
    task automatic run_session(input int base, input int n, input bit poke);
        int k, t;
        bit exp_err, ok;
        k = (base + n - 1 <= AMAX) ? n : (AMAX - base + 1);
        exp_err = (k < n);
        open_session(base);
        for (int i = 0; i < k; i++) begin
            wr_t e;
            e.addr = base + i;
            e.data = ref_word(s_op[i], s_rx[i], s_arg[i]);
            exp_q.push_back(e);
            send(s_op[i], s_rx[i], s_arg[i], (i == n - 1), poke && (i == 1), base, ok);
            if (!ok) break;
        end
        in_valid = 1'b0;
        t = 0;
        while (busy && t < 10) begin @(negedge clk); t++; end
        chk("end_busy", int'(busy), 0);
        chk("end_count", int'(count), k);
        chk("end_err", int'(err), int'(exp_err));
        chk("end_done_pulses", done_seen, exp_err ? 0 : 1);
        chk("end_queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic set_instr(input int i, input int op, input int rx, input int arg);
        s_op[i] = op; s_rx[i] = rx; s_arg[i] = arg;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset values while rst_n is held low
        #3;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_count", int'(count), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single LOAD R3 #5 at 0x10
        set_instr(0, 0, 3, 5);
        run_session(16, 1, 1'b0);

        // MATH R1 op2, MOVE R2 R7, JUMP R0 cond3
        set_instr(0, 5, 1, 2); set_instr(1, 4, 2, 7); set_instr(2, 6, 0, 3);
        run_session(32, 3, 1'b0);

        // NOP with nonzero operands is canonicalised
        set_instr(0, 7, 5, 6);
        run_session(64, 1, 1'b0);

        // Overflow from 0xFE: two writes, err, no done
        for (int i = 0; i < 3; i++) set_instr(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        run_session(254, 3, 1'b0);

        // Single last instruction at the top address completes normally
        set_instr(0, 2, 4, 1);
        run_session(255, 1, 1'b0);

        // start pulsed during ACCEPT of a live session is ignored
        for (int i = 0; i < 4; i++) set_instr(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        run_session(100, 4, 1'b1);

        // Reset in the WRITE cycle drops mem_we immediately
        begin
            wr_t e;
            open_session(48);
            e.addr = 48; e.data = ref_word(3, 6, 2);
            exp_q.push_back(e);
            send(3, 6, 2, 1'b0, 1'b0, 48, ok);
            chk("pre_rst_we", int'(mem_we), 1);
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_we", int'(mem_we), 0);
            chk("async_rst_busy", int'(busy), 0);
            chk("async_rst_ready", int'(in_ready), 0);
            chk("async_rst_count", int'(count), 0);
            chk("async_rst_addr", int'(mem_addr), 0);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            done_seen = 0;
            repeat (3) @(negedge clk);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_done", done_seen, 0);
            exp_q.delete();
        end
        set_instr(0, 1, 7, 4); set_instr(1, 7, 1, 1);
        run_session(49, 2, 1'b0);

        // Randomised sessions, biased toward the top of the address space
        for (int s = 0; s < 25; s++) begin
            int base, n;
            n = $urandom_range(1, 6);
            base = ($urandom_range(0, 1) == 1) ? $urandom_range(AMAX - 5, AMAX) : $urandom_range(0, AMAX);
            for (int i = 0; i < n; i++) set_instr(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            run_session(base, n, (n > 2) && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
